// File: rtl/game_state_engine.sv
// Pac-man style game core: movement ticks, pacman/ghost motion with arena
// clamping, ghost collision detection and the PLAY/DYING/RESPAWN/OVER life cycle.
module game_state_engine #(
    parameter int NUM_GHOSTS  = 4,
    parameter int TICK_DIV    = 2,
    parameter int PAC_STEP    = 1,
    parameter int GHOST_STEP  = 1,
    parameter int X_MIN       = 16,
    parameter int X_MAX       = 1008,
    parameter int Y_MIN       = 16,
    parameter int Y_MAX       = 752,
    parameter int HIT_DIST    = 16,
    parameter int LIVES       = 3,
    parameter int DEATH_TICKS = 60,
    parameter int PAC_RST_X   = 967,
    parameter int PAC_RST_Y   = 66,
    parameter logic [43:0] GHOST_RST_X = {11'd663, 11'd615, 11'd503, 11'd615},
    parameter logic [39:0] GHOST_RST_Y = {10'd434, 10'd258, 10'd66, 10'd370}
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rbtn,
    input  logic                       lbtn,
    input  logic                       ubtn,
    input  logic                       dbtn,
    input  logic [4*NUM_GHOSTS-1:0]    ghost_dir,
    output logic [10:0]                pacman_pos_x,
    output logic [9:0]                 pacman_pos_y,
    output logic [11*NUM_GHOSTS-1:0]   ghost_pos_x,
    output logic [10*NUM_GHOSTS-1:0]   ghost_pos_y,
    output logic [3:0]                 pacman_dir,
    output logic                       move_tick,
    output logic                       pacman_is_dead,
    output logic [2:0]                 lives_left,
    output logic                       game_over,
    output logic [1:0]                 state
);
    localparam logic [1:0] S_PLAY = 2'b00, S_DYING = 2'b01, S_RESPAWN = 2'b10, S_OVER = 2'b11;
    localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DEATH_W = $clog2(DEATH_TICKS + 1);
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [DEATH_W-1:0] DEATH_LAST = DEATH_W'(DEATH_TICKS - 1);
    localparam logic signed [11:0] X_LO = 12'(X_MIN), X_HI = 12'(X_MAX);
    localparam logic signed [11:0] Y_LO = 12'(Y_MIN), Y_HI = 12'(Y_MAX);
    localparam logic signed [11:0] PAC_S = 12'(PAC_STEP), GHOST_S = 12'(GHOST_STEP);
    localparam logic signed [11:0] HIT_S = 12'(HIT_DIST);

    // Signed 12-bit arithmetic keeps a step below the lower bound from wrapping.
    function automatic logic [10:0] step_clamp(input logic [10:0] pos, input logic inc,
                                               input logic dec, input logic signed [11:0] step,
                                               input logic signed [11:0] lo,
                                               input logic signed [11:0] hi);
        logic signed [11:0] cur;
        logic signed [11:0] nxt;
        cur = signed'({1'b0, pos});
        nxt = cur;
        if (inc)
            nxt = cur + step;
        else if (dec)
            nxt = cur - step;
        if (nxt < lo)
            nxt = lo;
        else if (nxt > hi)
            nxt = hi;
        return nxt[10:0];
    endfunction

    logic [1:0]          state_q, state_d;
    logic [10:0]         pac_x_q, pac_x_d;
    logic [9:0]          pac_y_q, pac_y_d;
    logic [3:0]          pac_dir_q, pac_dir_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic                move_tick_q, move_tick_d;
    logic                dead_q;
    logic [2:0]          lives_q, lives_d;
    logic [DEATH_W-1:0]  death_cnt_q, death_cnt_d;
    logic [NUM_GHOSTS-1:0] hit;
    logic                collide, move_en, load_rst;
    logic                unused_pac_y_msb;

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_PLAY;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_PLAY:    if (collide) state_d = S_DYING;
            S_DYING:   if (move_tick_q && death_cnt_q == DEATH_LAST)
                           state_d = (lives_q == 3'd0) ? S_OVER : S_RESPAWN;
            S_RESPAWN: state_d = S_PLAY;
            default:   state_d = S_OVER;
        endcase
    end

    always_comb begin
        collide   = (state_q == S_PLAY) && (|hit);
        move_en   = (state_q == S_PLAY) && move_tick_q && !collide;
        load_rst  = (state_q == S_RESPAWN);
        game_over = (state_q == S_OVER);
    end

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (state_q == S_RESPAWN)
            tick_cnt_d = '0;
        else if (state_q != S_OVER)
            tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
        move_tick_d = (state_d != S_OVER) && (tick_cnt_d == TICK_LAST);

        death_cnt_d = death_cnt_q;
        if (state_d != S_DYING)
            death_cnt_d = '0;
        else if (state_q == S_DYING && move_tick_q)
            death_cnt_d = death_cnt_q + 1'b1;

        lives_d = collide ? lives_q - 3'd1 : lives_q;

        pac_dir_d = pac_dir_q;
        if (load_rst)
            pac_dir_d = 4'b0000;
        else if (state_q == S_PLAY) begin
            if (rbtn)      pac_dir_d = 4'b0001;
            else if (lbtn) pac_dir_d = 4'b1000;
            else if (ubtn) pac_dir_d = 4'b0010;
            else if (dbtn) pac_dir_d = 4'b0100;
        end
    end

    // Screen coordinates: UP decreases y, DOWN increases y.
    assign pac_x_d = step_clamp(pac_x_q, pac_dir_q[0], pac_dir_q[3], PAC_S, X_LO, X_HI);
    assign {unused_pac_y_msb, pac_y_d} =
        step_clamp({1'b0, pac_y_q}, pac_dir_q[2], pac_dir_q[1], PAC_S, Y_LO, Y_HI);

    always_ff @(posedge clk) begin
        if (rst) begin
            pac_x_q     <= 11'(PAC_RST_X);
            pac_y_q     <= 10'(PAC_RST_Y);
            pac_dir_q   <= 4'b0000;
            tick_cnt_q  <= '0;
            move_tick_q <= 1'b0;
            dead_q      <= 1'b0;
            lives_q     <= 3'(LIVES);
            death_cnt_q <= '0;
        end else begin
            pac_dir_q   <= pac_dir_d;
            tick_cnt_q  <= tick_cnt_d;
            move_tick_q <= move_tick_d;
            dead_q      <= collide;
            lives_q     <= lives_d;
            death_cnt_q <= death_cnt_d;
            if (load_rst) begin
                pac_x_q <= 11'(PAC_RST_X);
                pac_y_q <= 10'(PAC_RST_Y);
            end else if (move_en) begin
                pac_x_q <= pac_x_d;
                pac_y_q <= pac_y_d;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_GHOSTS; gi++) begin : g_ghost
            logic [10:0]        x_q, x_d;
            logic [9:0]         y_q, y_d;
            logic [3:0]         dir;
            logic               valid;
            logic               unused_y_msb;
            logic signed [11:0] dx, dy;

            assign dir   = ghost_dir[gi*4 +: 4];
            assign valid = $onehot(dir);
            assign x_d   = step_clamp(x_q, valid & dir[0], valid & dir[3], GHOST_S, X_LO, X_HI);
            assign {unused_y_msb, y_d} =
                step_clamp({1'b0, y_q}, valid & dir[2], valid & dir[1], GHOST_S, Y_LO, Y_HI);

            always_ff @(posedge clk) begin
                if (rst || load_rst) begin
                    x_q <= GHOST_RST_X[gi*11 +: 11];
                    y_q <= GHOST_RST_Y[gi*10 +: 10];
                end else if (move_en) begin
                    x_q <= x_d;
                    y_q <= y_d;
                end
            end

            assign dx = signed'({1'b0, pac_x_q}) - signed'({1'b0, x_q});
            assign dy = signed'({2'b00, pac_y_q}) - signed'({2'b00, y_q});
            assign hit[gi] = (dx < HIT_S) && (dx > -HIT_S) && (dy < HIT_S) && (dy > -HIT_S);
            assign ghost_pos_x[gi*11 +: 11] = x_q;
            assign ghost_pos_y[gi*10 +: 10] = y_q;
        end
    endgenerate

    assign pacman_pos_x   = pac_x_q;
    assign pacman_pos_y   = pac_y_q;
    assign pacman_dir     = pac_dir_q;
    assign move_tick      = move_tick_q;
    assign pacman_is_dead = dead_q;
    assign lives_left     = lives_q;
    assign state          = state_q;
endmodule

// File: tb/tb_game_state_engine.sv
// Directed bench for game_state_engine: three instances cover default play,
// a double-ghost spawn collision and a single-life clamp/game-over scenario.
module tb_game_state_engine;
    localparam logic [43:0] GX_RST = {11'd663, 11'd615, 11'd503, 11'd615};
    localparam logic [39:0] GY_RST = {10'd434, 10'd258, 10'd66, 10'd370};

    logic clk = 1'b0;
    logic rbtn = 0, lbtn = 0, ubtn = 0, dbtn = 0;
    logic rst_a = 1, rst_b = 1, rst_c = 1;
    logic [15:0] gd_a = '0;
    logic [7:0]  gd_b = '0;
    logic [3:0]  gd_c = '0;

    logic [10:0] a_px, b_px, c_px;
    logic [9:0]  a_py, b_py, c_py;
    logic [43:0] a_gx;
    logic [39:0] a_gy;
    logic [21:0] b_gx;
    logic [19:0] b_gy;
    logic [10:0] c_gx;
    logic [9:0]  c_gy;
    logic [3:0]  a_dir, b_dir, c_dir;
    logic        a_mt, b_mt, c_mt, a_dead, b_dead, c_dead, a_go, b_go, c_go;
    logic [2:0]  a_lives, b_lives, c_lives;
    logic [1:0]  a_st, b_st, c_st;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    game_state_engine u_a (
        .clk(clk), .rst(rst_a), .rbtn(rbtn), .lbtn(lbtn), .ubtn(ubtn), .dbtn(dbtn),
        .ghost_dir(gd_a), .pacman_pos_x(a_px), .pacman_pos_y(a_py),
        .ghost_pos_x(a_gx), .ghost_pos_y(a_gy), .pacman_dir(a_dir), .move_tick(a_mt),
        .pacman_is_dead(a_dead), .lives_left(a_lives), .game_over(a_go), .state(a_st)
    );

    game_state_engine #(
        .NUM_GHOSTS(2),
        .GHOST_RST_X({11'd0, 11'd0, 11'd960, 11'd977}),
        .GHOST_RST_Y({10'd0, 10'd0, 10'd60, 10'd71})
    ) u_b (
        .clk(clk), .rst(rst_b), .rbtn(rbtn), .lbtn(lbtn), .ubtn(ubtn), .dbtn(dbtn),
        .ghost_dir(gd_b), .pacman_pos_x(b_px), .pacman_pos_y(b_py),
        .ghost_pos_x(b_gx), .ghost_pos_y(b_gy), .pacman_dir(b_dir), .move_tick(b_mt),
        .pacman_is_dead(b_dead), .lives_left(b_lives), .game_over(b_go), .state(b_st)
    );

    game_state_engine #(
        .NUM_GHOSTS(1), .TICK_DIV(1), .PAC_STEP(4), .LIVES(1), .DEATH_TICKS(3),
        .PAC_RST_X(1007),
        .GHOST_RST_X({33'd0, 11'd1000}),
        .GHOST_RST_Y({30'd0, 10'd106})
    ) u_c (
        .clk(clk), .rst(rst_c), .rbtn(rbtn), .lbtn(lbtn), .ubtn(ubtn), .dbtn(dbtn),
        .ghost_dir(gd_c), .pacman_pos_x(c_px), .pacman_pos_y(c_py),
        .ghost_pos_x(c_gx), .ghost_pos_y(c_gy), .pacman_dir(c_dir), .move_tick(c_mt),
        .pacman_is_dead(c_dead), .lives_left(c_lives), .game_over(c_go), .state(c_st)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int dead_cnt;
        logic [10:0] px_frz;
        logic [10:0] gx_frz;

        step(2);
        check("a_rst_px", a_px, 967);
        check("a_rst_py", a_py, 66);
        check("a_rst_dir", a_dir, 0);
        check("a_rst_mt", a_mt, 0);
        check("a_rst_dead", a_dead, 0);
        check("a_rst_lives", a_lives, 3);
        check("a_rst_state", a_st, 0);
        check("a_rst_go", a_go, 0);
        check("a_rst_gx", a_gx, GX_RST);
        check("a_rst_gy", a_gy, GY_RST);

        // Hold right for 10 cycles: 5 ticks, one pixel each.
        rst_a = 0;
        rbtn  = 1;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            check($sformatf("a_mt_cyc%0d", k), a_mt, k % 2);
        end
        rbtn = 0;
        check("a_run_px", a_px, 972);
        check("a_run_py", a_py, 66);
        check("a_run_dir", a_dir, 4'b0001);
        check("a_run_gx", a_gx, GX_RST);

        // Button priority R>L>U>D, no press holds.
        lbtn = 1; ubtn = 1; dbtn = 1;
        step(1);
        check("a_prio_left", a_dir, 4'b1000);
        lbtn = 0;
        step(1);
        check("a_prio_up", a_dir, 4'b0010);
        ubtn = 0;
        step(1);
        check("a_prio_down", a_dir, 4'b0100);
        dbtn = 0;
        step(3);
        check("a_hold_dir", a_dir, 4'b0100);

        // Ghost0 LEFT, ghost1 multi-bit (stationary), ghosts 2/3 idle, 20 ticks.
        gd_a = {4'b0000, 4'b0000, 4'b0011, 4'b1000};
        step(40);
        check("a_g0_x", a_gx[10:0], 595);
        check("a_g0_y", a_gy[9:0], 370);
        check("a_g1_x", a_gx[21:11], 503);
        check("a_g1_y", a_gy[19:10], 66);
        check("a_g23_x", a_gx[43:22], GX_RST[43:22]);

        // Pacman left vs ghost1 right on row 66: contact when the gap drops to 14.
        rst_a = 1;
        gd_a  = '0;
        step(1);
        rst_a = 0;
        lbtn  = 1;
        step(1);
        lbtn = 0;
        gd_a = 16'h0010;
        check("a_dir_left", a_dir, 4'b1000);
        n = 0;
        while (a_st != 2'b01 && n < 1000) begin
            step(1);
            n++;
        end
        check("a_enter_dying", a_st, 2'b01);
        check("a_lives_dec", a_lives, 2);
        check("a_dead_pulse", a_dead, 1);
        check("a_hit_px", a_px, 742);
        check("a_hit_g1x", a_gx[21:11], 728);
        px_frz = a_px;
        gx_frz = a_gx[21:11];
        step(10);
        check("a_frozen_state", a_st, 2'b01);
        check("a_frozen_px", a_px, 742);
        check("a_frozen_g1x", a_gx[21:11], 728);
        check("a_dead_done", a_dead, 0);
        // Reset mid-DYING.
        rst_a = 1;
        step(1);
        check("a_mid_rst_state", a_st, 0);
        check("a_mid_rst_lives", a_lives, 3);
        check("a_mid_rst_px", a_px, 967);
        check("a_mid_rst_dir", a_dir, 0);
        check("a_mid_rst_gx", a_gx, GX_RST);
        check("a_mid_rst_dead", a_dead, 0);
        gd_a = '0;

        // Two ghosts overlap pacman at spawn: single death, 60-tick freeze, respawn.
        rst_b = 0;
        step(1);
        check("b_state_dying", b_st, 2'b01);
        check("b_lives_dec1", b_lives, 2);
        check("b_dead_pulse", b_dead, 1);
        n = 0;
        dead_cnt = 0;
        while (b_st == 2'b01 && n < 300) begin
            step(1);
            n++;
            if (b_dead) dead_cnt++;
        end
        check("b_dying_len", n, 119);
        check("b_state_respawn", b_st, 2'b10);
        check("b_extra_pulses", dead_cnt, 0);
        check("b_lives_once", b_lives, 2);
        step(1);
        check("b_state_play", b_st, 0);
        check("b_resp_px", b_px, 967);
        check("b_resp_py", b_py, 66);
        check("b_resp_gx", b_gx, {11'd960, 11'd977});
        check("b_resp_dir", b_dir, 0);
        step(1);
        check("b_second_death", b_st, 2'b01);
        check("b_lives_dec2", b_lives, 1);
        check("b_dead_pulse2", b_dead, 1);
        rst_b = 1;

        // Clamp at X_MAX with a 4-pixel step, then single-life game over.
        rst_c = 0;
        rbtn  = 1;
        step(2);
        check("c_clamp_x", c_px, 1008);
        step(3);
        check("c_clamp_hold", c_px, 1008);
        check("c_mt_every", c_mt, 1);
        rbtn = 0;
        gd_c = 4'b0010;
        n = 0;
        while (c_st != 2'b01 && n < 200) begin
            step(1);
            n++;
        end
        check("c_enter_dying", c_st, 2'b01);
        check("c_lives_zero", c_lives, 0);
        check("c_ghost_y", c_gy, 81);
        n = 0;
        while (c_st != 2'b11 && n < 50) begin
            step(1);
            n++;
        end
        check("c_state_over", c_st, 2'b11);
        check("c_game_over", c_go, 1);
        check("c_over_mt", c_mt, 0);
        lbtn = 1; ubtn = 1;
        step(5);
        lbtn = 0; ubtn = 0;
        check("c_over_dir", c_dir, 4'b0001);
        check("c_over_px", c_px, 1008);
        check("c_over_gy", c_gy, 81);
        check("c_over_hold", c_st, 2'b11);
        rst_c = 1;
        step(1);
        check("c_rst_lives", c_lives, 1);
        check("c_rst_state", c_st, 0);
        check("c_rst_go", c_go, 0);
        check("c_rst_px", c_px, 1007);
        check("c_rst_dir", c_dir, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
